// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: basic datapath word type shared across the cpu
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/dcache_param_pkg.sv
// dcache_param_pkg: controller states and width helper for the parametrised dcache
package dcache_param_pkg;
    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNT, DONE} dstate_t;
    // index width that stays at least one bit for single-entry ranges
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dcache_victim_sel.sv
// dcache_victim_sel: picks the lowest invalid way, else the round-robin pointer
module dcache_victim_sel
    import dcache_param_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int WW = idx_w(WAYS)
)(
    input  logic [WAYS-1:0] valid,
    input  logic [WW-1:0]   ptr,
    output logic [WW-1:0]   victim
);
    // descending scan so the lowest-numbered invalid way wins
    always_comb begin
        victim = ptr;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!valid[w]) victim = WW'(w);
    end
endmodule

// File: rtl/dcache_param.sv
// dcache_param: write-back, write-allocate set-associative data cache with halt flush
module dcache_param
    import cpu_types_pkg::*;
    import dcache_param_pkg::*;
#(
    parameter int          SETS        = 8,
    parameter int          WAYS        = 2,
    parameter int          WORDS       = 2,
    parameter bit          HITCNT_EN   = 1'b1,
    parameter logic [31:0] HITCNT_ADDR = 32'h00003100
)(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - OW - IW;
    localparam int CW = idx_w(WORDS);
    localparam int WW = idx_w(WAYS);

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TW-1:0]          tag;
        word_t [WORDS-1:0]      data;
    } line_t;

    line_t         lines_q [SETS][WAYS];
    line_t         lines_d [SETS][WAYS];
    logic [WW-1:0] ptr_q [SETS];
    logic [WW-1:0] ptr_d [SETS];
    dstate_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] set_q, set_d;
    logic [WW-1:0] way_q, way_d;
    logic [TW-1:0] rtag_q, rtag_d;
    word_t         hits_q, hits_d;
    logic          flushed_q, flushed_d;
    logic          dren_q, dren_d, dwen_q, dwen_d;
    word_t         daddr_q, daddr_d, dstore_q, dstore_d;

    logic [IW-1:0]   ridx;
    logic [TW-1:0]   rtag;
    logic [CW-1:0]   roff;
    logic [WAYS-1:0] set_valid;
    logic            hit_any;
    logic [WW-1:0]   hit_way;
    logic [WW-1:0]   victim;
    logic            xfer;
    logic            last;
    line_t           cur;
    line_t           vline;

    function automatic word_t mk_addr(input logic [TW-1:0] t, input logic [IW-1:0] i, input logic [CW-1:0] c);
        return (32'(t) << (OW + IW + 2)) | (32'(i) << (OW + 2)) | (32'(c) << 2);
    endfunction

    assign roff  = CW'((dmemaddr >> 2) % WORDS);
    assign ridx  = IW'(dmemaddr >> (OW + 2));
    assign rtag  = TW'(dmemaddr >> (OW + IW + 2));
    assign xfer  = (dren_q | dwen_q) & ~dwait;
    assign last  = cnt_q == CW'(WORDS - 1);
    assign cur   = lines_q[set_q][way_q];
    assign vline = lines_q[set_d][way_d];

    // tag compare across every way of the addressed set
    always_comb begin
        set_valid = '0;
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            set_valid[w] = lines_q[ridx][w].valid;
            if (lines_q[ridx][w].valid && lines_q[ridx][w].tag == rtag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign dhit     = (state_q == IDLE) && !halt && (dmemREN || dmemWEN) && hit_any;
    assign dmemload = dhit ? lines_q[ridx][hit_way].data[roff] : '0;
    assign flushed  = flushed_q;
    assign dREN     = dren_q;
    assign dWEN     = dwen_q;
    assign daddr    = daddr_q;
    assign dstore   = dstore_q;

    dcache_victim_sel #(.WAYS(WAYS), .WW(WW)) u_victim (
        .valid  (set_valid),
        .ptr    (ptr_q[ridx]),
        .victim (victim)
    );

    // controller: hit updates, miss handling, flush scan and hit-count write
    always_comb begin
        lines_d   = lines_q;
        ptr_d     = ptr_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        way_d     = way_q;
        rtag_d    = rtag_q;
        hits_d    = hits_q;
        flushed_d = flushed_q;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                    set_d   = '0;
                    way_d   = '0;
                    cnt_d   = '0;
                end else if (dhit) begin
                    hits_d = hits_q + 32'd1;
                    if (dmemWEN) begin
                        lines_d[ridx][hit_way].data[roff] = dmemstore;
                        lines_d[ridx][hit_way].dirty      = 1'b1;
                    end
                end else if (dmemREN || dmemWEN) begin
                    set_d   = ridx;
                    rtag_d  = rtag;
                    way_d   = victim;
                    cnt_d   = '0;
                    state_d = lines_q[ridx][victim].dirty ? WB : FETCH;
                end
            end
            WB: begin
                if (xfer) begin
                    cnt_d = last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        lines_d[set_q][way_q].dirty = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (xfer) begin
                    lines_d[set_q][way_q].data[cnt_q] = dload;
                    cnt_d = last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        lines_d[set_q][way_q].valid = 1'b1;
                        lines_d[set_q][way_q].dirty = 1'b0;
                        lines_d[set_q][way_q].tag   = rtag_q;
                        if (WAYS > 1) ptr_d[set_q] = ptr_q[set_q] + WW'(1);
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (!cur.dirty || (xfer && last)) begin
                    lines_d[set_q][way_q].valid = 1'b0;
                    lines_d[set_q][way_q].dirty = 1'b0;
                    cnt_d = '0;
                    way_d = (way_q == WW'(WAYS - 1)) ? '0 : way_q + WW'(1);
                    if (way_q == WW'(WAYS - 1)) begin
                        set_d = set_q + IW'(1);
                        if (set_q == IW'(SETS - 1)) begin
                            state_d   = HITCNT_EN ? CNT : DONE;
                            flushed_d = ~HITCNT_EN;
                        end
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CNT: begin
                if (xfer) begin
                    state_d   = DONE;
                    flushed_d = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // memory-side request for the upcoming state, registered so it only moves on transfer edges
    always_comb begin
        dren_d   = state_d == FETCH;
        dwen_d   = (state_d == WB) || (state_d == CNT) || (state_d == FLUSH && vline.dirty);
        daddr_d  = '0;
        dstore_d = '0;
        if (state_d == CNT) begin
            daddr_d  = HITCNT_ADDR;
            dstore_d = hits_d;
        end else if (dren_d) begin
            daddr_d = mk_addr(rtag_d, set_d, cnt_d);
        end else if (dwen_d) begin
            daddr_d  = mk_addr(vline.tag, set_d, cnt_d);
            dstore_d = vline.data[cnt_d];
        end
    end

    // state registers; reset discards the whole cache and aborts any transfer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) lines_q[s][w] <= '0;
            end
            state_q   <= IDLE;
            cnt_q     <= '0;
            set_q     <= '0;
            way_q     <= '0;
            rtag_q    <= '0;
            hits_q    <= '0;
            flushed_q <= 1'b0;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= '0;
            dstore_q  <= '0;
        end else begin
            lines_q   <= lines_d;
            ptr_q     <= ptr_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            set_q     <= set_d;
            way_q     <= way_d;
            rtag_q    <= rtag_d;
            hits_q    <= hits_d;
            flushed_q <= flushed_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            daddr_q   <= daddr_d;
            dstore_q  <= dstore_d;
        end
    end
endmodule

// File: tb/tb_dcache_param.sv
// tb_dcache_param: directed and randomized checks of dcache_param against a memory/cache model
module tb_dcache_param;
    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int WORDS = 2;
    localparam int BLK_BYTES = 4 * WORDS;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    logic clk = 0, nRST = 0, halt = 0, dmemREN = 0, dmemWEN = 0;
    logic [31:0] dmemaddr = 0, dmemstore = 0;
    logic dhit, flushed, dREN, dWEN, dwait;
    logic [31:0] dmemload, daddr, dstore, dload;
    logic wait_force = 0, wait_rand = 0, rnd_w = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] gold [0:4095];
    xfer_t log_q [$];

    int mtag [SETS][WAYS];
    bit mval [SETS][WAYS];
    bit mdirty [SETS][WAYS];
    int mptr [SETS];
    int mhits;
    int n_checks = 0, n_fail = 0;

    dcache_param #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS), .HITCNT_EN(1'b1), .HITCNT_ADDR(32'h00003100)) dut (
        .CLK(clk), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait)
    );

    always #5 clk = ~clk;

    assign dwait = wait_force | (wait_rand & rnd_w);
    assign dload = mem[daddr[13:2]];

    initial forever begin
        @(posedge clk);
        #2;
        rnd_w = ($urandom_range(0, 2) == 0);
    end

    // memory responder and transfer log
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'hABCD0000;
        mem[1] = 32'hABCD1234;
        forever begin
            @(posedge clk);
            if (nRST && !dwait) begin
                if (dWEN) begin
                    log_q.push_back('{1'b1, daddr, dstore});
                    mem[daddr[13:2]] = dstore;
                end else if (dREN) begin
                    log_q.push_back('{1'b0, daddr, dload});
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_acc(input bit wr, input logic [31:0] a);
        int blk, s, v;
        blk = int'(a / BLK_BYTES);
        s = blk % SETS;
        mhits++;
        for (int w = 0; w < WAYS; w++)
            if (mval[s][w] && mtag[s][w] == blk) begin
                if (wr) mdirty[s][w] = 1;
                return 1;
            end
        v = -1;
        for (int w = 0; w < WAYS; w++)
            if (!mval[s][w] && v < 0) v = w;
        if (v < 0) v = mptr[s];
        mptr[s] = (mptr[s] + 1) % WAYS;
        mtag[s][v] = blk;
        mval[s][v] = 1;
        mdirty[s][v] = wr;
        return 0;
    endfunction

    task automatic do_reset();
        nRST = 0;
        halt = 0;
        dmemREN = 0;
        dmemWEN = 0;
        wait_force = 0;
        wait_rand = 0;
        #1;
        check("rst_dhit", 32'(dhit), 0);
        check("rst_dmemload", dmemload, 0);
        check("rst_dren", 32'(dREN), 0);
        check("rst_dwen", 32'(dWEN), 0);
        check("rst_daddr", daddr, 0);
        check("rst_dstore", dstore, 0);
        check("rst_flushed", 32'(flushed), 0);
        repeat (2) @(negedge clk);
        nRST = 1;
        for (int s = 0; s < SETS; s++) begin
            mptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                mval[s][w] = 0;
                mdirty[s][w] = 0;
            end
        end
        mhits = 0;
        for (int i = 0; i < 4096; i++) gold[i] = mem[i];
        log_q.delete();
    endtask

    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        dmemREN = !wr;
        dmemWEN = wr;
        dmemaddr = a;
        dmemstore = d;
        cyc = 0;
        #1;
        while (!dhit && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!dhit) check("acc_timeout", 32'(dhit), 1);
        rd = dmemload;
        @(posedge clk);
        #1;
        dmemREN = 0;
        dmemWEN = 0;
    endtask

    task automatic do_acc(input bit wr, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output int cyc);
        bit ph;
        ph = model_acc(wr, a);
        access(wr, a, d, rd, cyc);
        check("hit_pred", 32'(cyc == 0), 32'(ph));
        if (wr) gold[a[13:2]] = d;
        else check("rdata", rd, gold[a[13:2]]);
    endtask

    task automatic chk_xfer(input string tag, input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (i >= log_q.size()) check({tag, "_missing"}, 32'(log_q.size()), 32'(i + 1));
        else begin
            check({tag, "_kind"}, 32'(log_q[i].wr), 32'(wr));
            check({tag, "_addr"}, log_q[i].a, a);
            check({tag, "_data"}, log_q[i].d, d);
        end
    endtask

    task automatic do_flush();
        int n;
        n = 0;
        @(negedge clk);
        halt = 1;
        while (!flushed && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("flushed", 32'(flushed), 1);
        repeat (3) @(negedge clk);
        dmemREN = 1;
        dmemaddr = 0;
        #1;
        check("flushed_sticky", 32'(flushed), 1);
        check("done_dhit", 32'(dhit), 0);
        check("done_dren", 32'(dREN), 0);
        check("done_dwen", 32'(dWEN), 0);
        dmemREN = 0;
    endtask

    initial begin
        logic [31:0] rd, exp_w1, exp_w13;
        int cyc, n;
        do_reset();

        do_acc(0, 32'h04, 0, rd, cyc);
        check("t1_rd", rd, 32'hABCD1234);
        check("t1_cyc", 32'(cyc), WORDS + 1);
        check("t1_nxfer", 32'(log_q.size()), 2);
        chk_xfer("t1_x0", 0, 0, 32'h00, 32'hABCD0000);
        chk_xfer("t1_x1", 1, 0, 32'h04, 32'hABCD1234);
        log_q.delete();
        do_acc(0, 32'h00, 0, rd, cyc);
        check("t1_hit_rd", rd, 32'hABCD0000);
        check("t1_hit_nomem", 32'(log_q.size()), 0);

        do_acc(1, 32'h04, 32'hDEADBEEF, rd, cyc);
        check("t2_wr_cyc", 32'(cyc), 0);
        do_acc(0, 32'h04, 0, rd, cyc);
        check("t2_rd", rd, 32'hDEADBEEF);
        check("t2_nomem", 32'(log_q.size()), 0);

        do_acc(0, 32'h40, 0, rd, cyc);
        log_q.delete();
        do_acc(0, 32'h80, 0, rd, cyc);
        check("t3_cyc", 32'(cyc), 2 * WORDS + 1);
        check("t3_nxfer", 32'(log_q.size()), 4);
        chk_xfer("t3_wb0", 0, 1, 32'h00, 32'hABCD0000);
        chk_xfer("t3_wb1", 1, 1, 32'h04, 32'hDEADBEEF);
        chk_xfer("t3_f0", 2, 0, 32'h80, gold[32]);
        chk_xfer("t3_f1", 3, 0, 32'h84, gold[33]);

        wait_force = 1;
        log_q.delete();
        fork
            do_acc(0, 32'hC8, 0, rd, cyc);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    #2;
                    n++;
                end while (!dREN && n < 20);
                for (int k = 0; k < 4; k++) begin
                    check("t4_hold_addr", daddr, 32'hC8);
                    check("t4_hold_dren", 32'(dREN), 1);
                    if (k < 3) begin
                        @(negedge clk);
                        #2;
                    end
                end
                check("t4_no_xfer", 32'(log_q.size()), 0);
                wait_force = 0;
                @(negedge clk);
                #2;
                check("t4_advance", daddr, 32'hCC);
            end
        join
        check("t4_cyc", 32'(cyc), 6);

        wait_rand = 1;
        for (int i = 0; i < 300; i++)
            do_acc($urandom_range(0, 1), {22'd0, 7'($urandom_range(0, 127)), 2'b00}, $urandom, rd, cyc);
        wait_rand = 0;
        log_q.delete();
        do_flush();
        if (log_q.size() == 0) check("rnd_cnt_missing", 0, 1);
        else begin
            check("rnd_cnt_addr", log_q[log_q.size() - 1].a, 32'h3100);
            check("rnd_cnt_val", log_q[log_q.size() - 1].d, 32'(mhits));
        end
        for (int i = 0; i < 128; i++) check("rnd_mem", mem[i], gold[i]);

        do_reset();
        do_acc(1, 32'h10, 32'h5A5A5A5A, rd, cyc);
        do_acc(0, 32'h50, 0, rd, cyc);
        wait_force = 1;
        @(negedge clk);
        dmemREN = 1;
        dmemaddr = 32'h90;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!dWEN && n < 10);
        check("t6_wb_dwen", 32'(dWEN), 1);
        check("t6_wb_addr", daddr, 32'h10);
        #2;
        nRST = 0;
        #1;
        check("t6_dwen", 32'(dWEN), 0);
        check("t6_dren", 32'(dREN), 0);
        check("t6_daddr", daddr, 0);
        check("t6_dstore", dstore, 0);
        check("t6_dhit", 32'(dhit), 0);
        do_reset();
        do_acc(0, 32'h10, 0, rd, cyc);
        check("t6_remiss", 32'(cyc > 0), 1);

        do_reset();
        exp_w1 = gold[1];
        exp_w13 = gold[19];
        do_acc(1, 32'h00, 32'h11111111, rd, cyc);
        do_acc(1, 32'h48, 32'h22222222, rd, cyc);
        do_acc(0, 32'h00, 0, rd, cyc);
        do_acc(0, 32'h04, 0, rd, cyc);
        do_acc(0, 32'h4C, 0, rd, cyc);
        log_q.delete();
        do_flush();
        check("t5_nxfer", 32'(log_q.size()), 5);
        chk_xfer("t5_w0", 0, 1, 32'h00, 32'h11111111);
        chk_xfer("t5_w1", 1, 1, 32'h04, exp_w1);
        chk_xfer("t5_w2", 2, 1, 32'h48, 32'h22222222);
        chk_xfer("t5_w3", 3, 1, 32'h4C, exp_w13);
        chk_xfer("t5_cnt", 4, 1, 32'h3100, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
